// File: rtl/mysystem_sum_engine_if.sv
// Avalon-MM slave bus bundle for the sum engine: word address, select, write strobe and data,
// registered read data.
interface mysystem_sum_engine_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/mysystem_sum_engine.sv
// Arithmetic-series sum engine: RESULT = sum(SEED + i) for i = 0..COUNT-1, one term per cycle,
// followed by a DONE_PULSE-cycle completion pulse on done_out.
module mysystem_sum_engine #(
    parameter int unsigned DONE_PULSE = 4,
    parameter int unsigned COUNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mysystem_sum_engine_if.slave  bus,
    output logic                  done_out,
    output logic                  busy_out
);

    typedef enum logic [1:0] {StIdle, StRun, StPulse} state_e;

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [31:0]          seed_q, seed_d;
    logic [31:0]          result_q, result_d;
    logic [31:0]          acc_q, acc_d;
    logic [COUNT_W-1:0]   idx_q, idx_d;
    logic [7:0]           pulse_q, pulse_d;
    logic                 sticky_q, sticky_d;
    logic                 aborted_q, aborted_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;

    logic                 wr_en;
    logic                 ctrl_wr;
    logic                 start_req;
    logic                 abort_req;
    logic [31:0]          sum_next;

    assign wr_en     = bus.chipselect && !bus.write_n;
    assign ctrl_wr   = wr_en && (bus.address == 2'd0);
    // Abort takes priority: start+abort in one write is an abort only.
    assign abort_req = ctrl_wr && bus.writedata[1];
    assign start_req = ctrl_wr && bus.writedata[0] && !bus.writedata[1];
    assign sum_next  = acc_q + seed_q + 32'(idx_q);

    // Next-state logic for the FSM, datapath and bus-visible registers.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        seed_d    = seed_q;
        result_d  = result_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        pulse_d   = pulse_q;
        sticky_d  = sticky_q;
        aborted_d = aborted_q;

        // Operand registers are frozen while a run is in flight.
        if (wr_en && !busy_q) begin
            if (bus.address == 2'd1) count_d = bus.writedata[COUNT_W-1:0];
            if (bus.address == 2'd2) seed_d  = bus.writedata;
        end

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    acc_d     = '0;
                    idx_d     = '0;
                    sticky_d  = 1'b0;
                    aborted_d = 1'b0;
                    if (count_q != '0) begin
                        state_d = StRun;
                    end else begin
                        state_d  = StPulse;
                        result_d = '0;
                        pulse_d  = '0;
                    end
                end
            end
            StRun: begin
                if (abort_req) begin
                    state_d   = StIdle;
                    aborted_d = 1'b1;
                end else begin
                    acc_d = sum_next;
                    idx_d = idx_q + COUNT_W'(1);
                    if (idx_q == count_q - COUNT_W'(1)) begin
                        result_d = sum_next;
                        state_d  = StPulse;
                        pulse_d  = '0;
                    end
                end
            end
            StPulse: begin
                if (pulse_q == 8'(DONE_PULSE - 1)) begin
                    state_d  = StIdle;
                    sticky_d = 1'b1;
                end else begin
                    pulse_d = pulse_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered copies of the upcoming state, so no bus-to-output path exists.
        done_d = (state_d == StPulse);
        busy_d = (state_d == StRun);

        case (bus.address)
            2'd0:    rdata_d = {29'b0, aborted_q, sticky_q, busy_q};
            2'd1:    rdata_d = 32'(count_q);
            2'd2:    rdata_d = seed_q;
            default: rdata_d = result_q;
        endcase
    end

    // State and register update with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            count_q   <= '0;
            seed_q    <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            pulse_q   <= '0;
            sticky_q  <= 1'b0;
            aborted_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            seed_q    <= seed_d;
            result_q  <= result_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            pulse_q   <= pulse_d;
            sticky_q  <= sticky_d;
            aborted_q <= aborted_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign done_out     = done_q;
    assign busy_out     = busy_q;

endmodule

// File: tb/tb_mysystem_sum_engine.sv
// Self-checking bench for mysystem_sum_engine: table of jobs with a result scoreboard, plus
// directed abort, in-flight write and reset-during-pulse sequences.
module tb_mysystem_sum_engine;

    localparam int unsigned DP = 4;

    typedef struct {
        logic [31:0] seed;
        logic [15:0] count;
        logic [31:0] exp_result;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic done_out;
    logic busy_out;

    mysystem_sum_engine_if bus_if ();

    mysystem_sum_engine #(
        .DONE_PULSE (DP),
        .COUNT_W    (16)
    ) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .done_out (done_out),
        .busy_out (busy_out)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    int          edge_cnt = 0;
    logic        done_prev = 1'b0;

    // Downstream PIO model: falling edge of done_out sets edge_capture.
    always @(negedge clk) begin
        if (!reset_n) begin
            done_prev <= 1'b0;
        end else begin
            if (done_prev && !done_out) edge_cnt <= edge_cnt + 1;
            done_prev <= done_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.address = a;
        @(negedge clk);
        d = bus_if.readdata;
    endtask

    // Runs one job and checks busy/done timing, result (via scoreboard), status and PIO edge.
    task automatic run_job(input logic [31:0] seed, input logic [15:0] count,
                           input logic [31:0] exp_result);
        int          busy_cnt;
        int          done_cnt;
        int          first_done;
        int          edges0;
        logic [31:0] r;
        logic [31:0] e;
        busy_cnt   = 0;
        done_cnt   = 0;
        first_done = 0;
        bus_write(2'd2, seed);
        bus_write(2'd1, 32'(count));
        edges0 = edge_cnt;
        bus_write(2'd0, 32'h1);
        sb_q.push_back(exp_result);
        // Now at the falling edge inside cycle T+1.
        for (int k = 1; k <= int'(count) + int'(DP) + 4; k++) begin
            if (busy_out) busy_cnt++;
            if (done_out) begin
                done_cnt++;
                if (first_done == 0) first_done = k;
            end
            @(negedge clk);
        end
        check("busy_cycles", 32'(busy_cnt), 32'(count));
        check("done_cycles", 32'(done_cnt), 32'(DP));
        check("done_start", 32'(first_done), 32'(count) + 32'd1);
        check("pio_edge", 32'(edge_cnt), 32'(edges0 + 1));
        bus_read(2'd3, r);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("result", r, e);
        end
        bus_read(2'd0, r);
        check("status_done", r, 32'h2);
        bus_read(2'd1, r);
        check("count_rb", r, 32'(count));
    endtask

    vec_t        vecs[7];
    logic [31:0] r;
    int          edges0;
    int          cnt;

    initial begin
        vecs[0] = '{32'd5,         16'd4,  32'd26};
        vecs[1] = '{32'd0,         16'd0,  32'd0};
        vecs[2] = '{32'hFFFF_FFFF, 16'd2,  32'hFFFF_FFFF};
        vecs[3] = '{32'd1,         16'd1,  32'd1};
        vecs[4] = '{32'd10,        16'd3,  32'd33};
        vecs[5] = '{32'h8000_0000, 16'd2,  32'd1};
        vecs[6] = '{32'd7,         16'd10, 32'd115};

        bus_if.address    = 2'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = '0;

        // Reset state.
        #1;
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_rdata", bus_if.readdata, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), r);
            check("rst_reg", r, 32'd0);
        end

        // Table-driven jobs.
        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].seed, vecs[i].count, vecs[i].exp_result);
        end

        // Abort mid-run; start written together with abort is ignored.
        bus_write(2'd2, 32'd3);
        bus_write(2'd1, 32'd100);
        edges0 = edge_cnt;
        bus_write(2'd0, 32'h1);
        repeat (9) @(negedge clk);
        check("abort_busy_before", 32'(busy_out), 32'd1);
        bus_write(2'd0, 32'h3);
        check("abort_busy_after", 32'(busy_out), 32'd0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (done_out || busy_out) cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(cnt), 32'd0);
        bus_read(2'd0, r);
        check("abort_status", r, 32'h4);
        bus_read(2'd3, r);
        check("abort_result_held", r, 32'd115);
        check("abort_no_edge", 32'(edge_cnt), 32'(edges0));
        // start+abort in idle: nothing happens.
        bus_write(2'd0, 32'h3);
        @(negedge clk);
        check("idle_abort_busy", 32'(busy_out), 32'd0);
        bus_read(2'd0, r);
        check("idle_abort_status", r, 32'h4);

        // Start and SEED write during run are ignored.
        bus_write(2'd2, 32'd2);
        bus_write(2'd1, 32'd6);
        edges0 = edge_cnt;
        bus_write(2'd0, 32'h1);
        sb_q.push_back(32'd27);
        bus_write(2'd2, 32'd100);
        bus_write(2'd0, 32'h1);
        cnt = 0;
        while (edge_cnt == edges0 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("inflight_edge", 32'(edge_cnt), 32'(edges0 + 1));
        bus_read(2'd3, r);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            check("inflight_result", r, sb_q.pop_front());
        end
        bus_read(2'd2, r);
        check("inflight_seed", r, 32'd2);
        repeat (10) @(negedge clk);
        check("inflight_no_rerun", 32'(edge_cnt), 32'(edges0 + 1));

        // Reset pulsed during the done pulse.
        bus_write(2'd2, 32'd1);
        bus_write(2'd1, 32'd1);
        edges0 = edge_cnt;
        bus_write(2'd0, 32'h1);
        cnt = 0;
        while (!done_out && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("pulse_reached", 32'(done_out), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_pulse_done", 32'(done_out), 32'd0);
        check("rst_pulse_busy", 32'(busy_out), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), r);
            check("rst_pulse_reg", r, 32'd0);
        end
        repeat (6) @(negedge clk);
        check("rst_pulse_no_edge", 32'(edge_cnt), 32'(edges0));

        // First start after reset.
        run_job(32'd5, 16'd4, 32'd26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
